// File: rtl/rom_cache_pkg.sv
// Shared types and helpers for the direct-mapped cartridge ROM line cache.
package rom_cache_pkg;

  localparam int LINE_WORDS = 4;
  localparam int LINE_BITS  = 64;

  typedef enum logic [2:0] {DRAIN, CLEAR, IDLE, LOOKUP, FILL, RESP} state_t;

  // Tag portion of a word address: everything above the line index.
  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int idx_w);
    return addr >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/rom_cache_ram.sv
// Generic single-port synchronous RAM with registered read (old data on write).
module rom_cache_ram #(
  parameter int DW = 64,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/rom_line_cache.sv
// Direct-mapped 4x16-bit line cache between the core ROM port and the DDR3 ROM controller.
// Optional hit/miss counters are enabled by defining ROM_CACHE_STATS_EN.
module rom_line_cache
  import rom_cache_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int AW    = 22
) (
  input  logic                 MCLK,
  input  logic                 RESET_N,
  input  logic                 flush,
  input  logic [AW-1:0]        cpu_addr,
  input  logic                 cpu_req,
  output logic                 cpu_ack,
  output logic [15:0]          cpu_dout,
  output logic [AW-3:0]        mem_addr,
  output logic                 mem_req,
  input  logic                 mem_ack,
  input  logic [LINE_BITS-1:0] mem_dout
`ifdef ROM_CACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);

  localparam int TAG_W = AW - IDX_W - 2;
  localparam int SEL_W = $clog2(LINE_WORDS);

  state_t               state, state_nxt;
  logic [AW-1:0]        req_addr;
  logic [IDX_W:0]       clr_cnt, clr_inc;
  logic [2**IDX_W-1:0]  valid;
  logic                 flush_seen, flush_any;
  logic [IDX_W-1:0]     ram_idx, req_idx;
  logic [TAG_W-1:0]     req_tag, tag_rd;
  logic [LINE_BITS-1:0] line_rd;
  logic                 req_pend, mem_done, hit, fill_we;

  function automatic logic [15:0] pick(input logic [LINE_BITS-1:0] line,
                                       input logic [SEL_W-1:0] sel);
    return line[{sel, 4'b0000} +: 16];
  endfunction

  assign req_pend  = (cpu_req != cpu_ack);
  assign mem_done  = (mem_ack == mem_req);
  assign req_idx   = req_addr[IDX_W+1:2];
  assign req_tag   = TAG_W'(tag_of(32'(req_addr), IDX_W));
  assign hit       = valid[req_idx] && (tag_rd == req_tag);
  assign fill_we   = (state == FILL) && mem_done;
  assign flush_any = flush_seen | flush;
  assign clr_inc   = clr_cnt + (IDX_W+1)'(1);

  // The RAM read is launched from the live address while idle so LOOKUP sees it next cycle.
  assign ram_idx = (state == IDLE) ? cpu_addr[IDX_W+1:2] : req_idx;

  rom_cache_ram #(.DW(LINE_BITS), .AW(IDX_W)) u_data (
    .clk   (MCLK),
    .we    (fill_we),
    .addr  (ram_idx),
    .wdata (mem_dout),
    .rdata (line_rd)
  );

  rom_cache_ram #(.DW(TAG_W), .AW(IDX_W)) u_tag (
    .clk   (MCLK),
    .we    (fill_we),
    .addr  (ram_idx),
    .wdata (req_tag),
    .rdata (tag_rd)
  );

  always_ff @(posedge MCLK) begin
    if (!RESET_N)
      state <= DRAIN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DRAIN:  if (mem_done) state_nxt = CLEAR;
      CLEAR:  if (clr_inc[IDX_W] && !flush) state_nxt = IDLE;
      IDLE: begin
        if (flush || flush_seen)
          state_nxt = CLEAR;
        else if (req_pend)
          state_nxt = LOOKUP;
      end
      LOOKUP: state_nxt = hit ? IDLE : FILL;
      FILL:   if (mem_done) state_nxt = RESP;
      RESP:   state_nxt = flush_any ? CLEAR : IDLE;
      default: state_nxt = DRAIN;
    endcase
  end

  // flush_seen remembers a flush that arrived mid-transaction so the line stays invalid
  // and the cache is cleared once the response has gone out.
  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      cpu_ack    <= cpu_req;
      cpu_dout   <= '0;
      mem_addr   <= '0;
      valid      <= '0;
      clr_cnt    <= '0;
      flush_seen <= 1'b0;
      req_addr   <= '0;
    end else begin
      if (flush && (state == LOOKUP || state == FILL || state == RESP))
        flush_seen <= 1'b1;
      case (state)
        CLEAR: begin
          valid[clr_cnt[IDX_W-1:0]] <= 1'b0;
          clr_cnt    <= {1'b0, clr_inc[IDX_W-1:0]};
          flush_seen <= 1'b0;
        end
        IDLE: begin
          if (!flush && !flush_seen && req_pend)
            req_addr <= cpu_addr;
        end
        LOOKUP: begin
          if (hit) begin
            cpu_dout <= pick(line_rd, req_addr[SEL_W-1:0]);
            cpu_ack  <= cpu_req;
          end else begin
            mem_addr <= req_addr[AW-1:2];
          end
        end
        FILL: begin
          if (mem_done) begin
            valid[req_idx] <= !flush_any;
            cpu_dout       <= pick(mem_dout, req_addr[SEL_W-1:0]);
          end
        end
        RESP: cpu_ack <= cpu_req;
        default: ;
      endcase
    end
  end

  // mem_req is deliberately not reset so a fill in flight across reset can be drained.
  always_ff @(posedge MCLK) begin
    if (RESET_N && state == LOOKUP && !hit)
      mem_req <= ~mem_req;
  end

`ifdef ROM_CACHE_STATS_EN
  logic flush_q;

  always_ff @(posedge MCLK) begin
    if (!RESET_N) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      flush_q  <= 1'b0;
    end else begin
      flush_q <= flush;
      if (flush && !flush_q) begin
        hit_cnt  <= '0;
        miss_cnt <= '0;
      end else if (state == LOOKUP) begin
        if (hit && hit_cnt != 32'hFFFF_FFFF)
          hit_cnt <= hit_cnt + 32'd1;
        if (!hit && miss_cnt != 32'hFFFF_FFFF)
          miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rom_line_cache.sv
// Self-checking bench for rom_line_cache: vector table, random reads against a cache model,
// and hand sequences for flush and reset corner cases.
module tb_rom_line_cache;

  localparam int IDX_W = 8;
  localparam int AW    = 22;

  logic          MCLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_req = 1'b1;
  logic          cpu_ack;
  logic [15:0]   cpu_dout;
  logic [AW-3:0] mem_addr;
  logic          mem_req;
  logic          mem_ack = 1'b0;
  logic [63:0]   mem_dout = '0;
`ifdef ROM_CACHE_STATS_EN
  logic [31:0]   hit_cnt, miss_cnt;
`endif

  rom_line_cache #(.IDX_W(IDX_W), .AW(AW)) dut (
    .MCLK     (MCLK),
    .RESET_N  (RESET_N),
    .flush    (flush),
    .cpu_addr (cpu_addr),
    .cpu_req  (cpu_req),
    .cpu_ack  (cpu_ack),
    .cpu_dout (cpu_dout),
    .mem_addr (mem_addr),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_dout (mem_dout)
`ifdef ROM_CACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 MCLK = ~MCLK;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;

  always @(posedge MCLK) cycleCount <= cycleCount + 1;

  // Backing ROM image: one recognisable line, every other line derived from its address.
  function automatic logic [63:0] romLine(input logic [AW-3:0] line);
    logic [15:0] l;
    l = 16'(line);
    if (line == 20'h00040)
      return 64'h4444_3333_2222_1111;
    return {l ^ 16'hD003, l ^ 16'hC002, l ^ 16'hB001, l ^ 16'hA000};
  endfunction

  function automatic logic [15:0] expWord(input logic [AW-1:0] a);
    logic [63:0] ln;
    ln = romLine(a[AW-1:2]);
    return 16'(ln >> (32'(a[1:0]) * 16));
  endfunction

  // Cache model: which tag each line slot holds, cleared wholesale by any flush.
  bit          modelValid [256];
  logic [11:0] modelTag   [256];

  function automatic bit modelLookup(input logic [AW-1:0] a);
    int idx;
    bit h;
    idx = int'(a[9:2]);
    h = modelValid[idx] && (modelTag[idx] == a[21:10]);
    if (!h) begin
      modelValid[idx] = 1'b1;
      modelTag[idx]   = a[21:10];
    end
    return h;
  endfunction

  task automatic modelFlush();
    for (int i = 0; i < 256; i++) modelValid[i] = 1'b0;
  endtask

  // Downstream memory responder with programmable latency.
  bit           respEnable = 1'b1;
  int           memDelay = 1;
  int           waitCnt = 0;
  int           fillCount = 0;
  int           ackDriveCycle = 0;
  logic [AW-3:0] lastFillLine = '0;

  initial begin
    forever begin
      @(posedge MCLK);
      #1;
      if (respEnable && RESET_N && mem_req !== mem_ack) begin
        waitCnt++;
        if (waitCnt >= memDelay) begin
          mem_dout      = romLine(mem_addr);
          mem_ack       = mem_req;
          lastFillLine  = mem_addr;
          ackDriveCycle = cycleCount;
          fillCount++;
          waitCnt = 0;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  int startCycle;
  int fillsBefore;

  task automatic startRead(input logic [AW-1:0] a);
    cpu_addr    = a;
    cpu_req     = ~cpu_req;
    startCycle  = cycleCount;
    fillsBefore = fillCount;
  endtask

  task automatic waitAck(input int budget, output bit timedOut, output int lat,
                         output bit missed, output int endCycle);
    timedOut = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(posedge MCLK);
      #1;
      if (cpu_ack == cpu_req) begin
        timedOut = 1'b0;
        break;
      end
    end
    missed   = (fillCount != fillsBefore);
    lat      = missed ? (cycleCount - ackDriveCycle) : (cycleCount - startCycle);
    endCycle = cycleCount;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    bit            expMiss;
    logic [15:0]   expData;
  } vec_t;

  vec_t vecs [8];

  task automatic applyStimulus(input vec_t v);
    bit to, ms;
    int lat, ec;
    void'(modelLookup(v.addr));
    startRead(v.addr);
    waitAck(600, to, lat, ms, ec);
    checkOutput($sformatf("vec_timeout_%0h", v.addr), 64'(to), 64'd0);
    checkOutput($sformatf("vec_data_%0h", v.addr), 64'(cpu_dout), 64'(v.expData));
    checkOutput($sformatf("vec_miss_%0h", v.addr), 64'(ms), 64'(v.expMiss));
    checkOutput($sformatf("vec_latency_%0h", v.addr), 64'(lat), 64'd2);
    if (v.expMiss)
      checkOutput($sformatf("vec_mem_addr_%0h", v.addr), 64'(lastFillLine), 64'(v.addr >> 2));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit to, ms, stayed;
    int lat, ec, sc;
    logic [AW-1:0] a;

    vecs[0] = '{22'h000100, 1'b1, 16'h1111};
    vecs[1] = '{22'h000101, 1'b0, 16'h2222};
    vecs[2] = '{22'h000102, 1'b0, 16'h3333};
    vecs[3] = '{22'h000103, 1'b0, 16'h4444};
    vecs[4] = '{22'h000500, 1'b1, 16'hA140};
    vecs[5] = '{22'h000100, 1'b1, 16'h1111};
    vecs[6] = '{22'h000503, 1'b1, 16'hD143};
    vecs[7] = '{22'h000101, 1'b1, 16'h2222};

    modelFlush();

    // Reset values while RESET_N is low.
    repeat (4) @(posedge MCLK);
    #1;
    checkOutput("reset_cpu_ack", 64'(cpu_ack), 64'(cpu_req));
    checkOutput("reset_cpu_dout", 64'(cpu_dout), 64'd0);
    checkOutput("reset_mem_addr", 64'(mem_addr), 64'd0);
    RESET_N = 1'b1;
    repeat (300) @(posedge MCLK);
    #1;
    checkOutput("post_reset_no_ack", 64'(cpu_ack), 64'(cpu_req));
    checkOutput("post_reset_no_fill", 64'(fillCount), 64'd0);

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    $display("[TB] random reads");
    for (int n = 0; n < 200; n++) begin
      bit expHit;
      a = AW'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      memDelay = int'($urandom_range(1, 6));
      expHit = modelLookup(a);
      startRead(a);
      waitAck(600, to, lat, ms, ec);
      checkOutput($sformatf("rnd_timeout_%0d", n), 64'(to), 64'd0);
      checkOutput($sformatf("rnd_data_%0d_%0h", n, a), 64'(cpu_dout), 64'(expWord(a)));
      checkOutput($sformatf("rnd_miss_%0d_%0h", n, a), 64'(ms), 64'(!expHit));
      checkOutput($sformatf("rnd_latency_%0d", n), 64'(lat), 64'd2);
    end

    $display("[TB] one-cycle flush with request pending during clear");
    memDelay = 2;
    flush = 1'b1;
    @(posedge MCLK);
    #1;
    flush = 1'b0;
    modelFlush();
    startRead(22'h000101);
    sc = startCycle;
    waitAck(800, to, lat, ms, ec);
    checkOutput("flush_timeout", 64'(to), 64'd0);
    checkOutput("flush_waited_clear", 64'(ec - sc >= 256), 64'd1);
    checkOutput("flush_prior_hit_misses", 64'(ms), 64'd1);
    checkOutput("flush_data", 64'(cpu_dout), 64'h2222);
    void'(modelLookup(22'h000101));

    $display("[TB] flush during fill");
    memDelay = 10;
    startRead(22'h0002A8);
    repeat (4) @(posedge MCLK);
    #1;
    flush = 1'b1;
    @(posedge MCLK);
    #1;
    flush = 1'b0;
    waitAck(600, to, lat, ms, ec);
    checkOutput("fillflush_timeout", 64'(to), 64'd0);
    checkOutput("fillflush_data", 64'(cpu_dout), 64'(expWord(22'h0002A8)));
    checkOutput("fillflush_miss", 64'(ms), 64'd1);
    checkOutput("fillflush_latency", 64'(lat), 64'd2);
    modelFlush();
    memDelay = 2;
    startRead(22'h0002A9);
    waitAck(800, to, lat, ms, ec);
    checkOutput("fillflush_repeat_timeout", 64'(to), 64'd0);
    checkOutput("fillflush_repeat_miss", 64'(ms), 64'd1);
    checkOutput("fillflush_repeat_data", 64'(cpu_dout), 64'(expWord(22'h0002A9)));
    void'(modelLookup(22'h0002A9));

    $display("[TB] reset with fill outstanding");
    startRead(22'h0003F0);
    waitAck(600, to, lat, ms, ec);
    checkOutput("rst_prime_data", 64'(cpu_dout), 64'(expWord(22'h0003F0)));
    startRead(22'h0003F1);
    waitAck(600, to, lat, ms, ec);
    checkOutput("rst_prime_hit", 64'(ms), 64'd0);
    respEnable = 1'b0;
    startRead(22'h0007F4);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge MCLK);
      #1;
      if (mem_req !== mem_ack) begin
        to = 1'b0;
        break;
      end
    end
    checkOutput("rst_fill_outstanding", 64'(to), 64'd0);
    RESET_N = 1'b0;
    repeat (3) @(posedge MCLK);
    #1;
    checkOutput("rst_cpu_ack_follows", 64'(cpu_ack), 64'(cpu_req));
    checkOutput("rst_cpu_dout", 64'(cpu_dout), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    RESET_N = 1'b1;
    stayed = 1'b1;
    repeat (5) begin
      @(posedge MCLK);
      #1;
      if (cpu_ack != cpu_req) stayed = 1'b0;
    end
    mem_dout = 64'hDEAD_BEEF_0BAD_F00D;
    mem_ack  = mem_req;
    repeat (300) begin
      @(posedge MCLK);
      #1;
      if (cpu_ack != cpu_req) stayed = 1'b0;
    end
    checkOutput("rst_no_cpu_ack_toggle", 64'(stayed), 64'd1);
    checkOutput("rst_no_extra_mem_req", 64'(mem_req == mem_ack), 64'd1);
    respEnable = 1'b1;
    memDelay = 3;
    modelFlush();
    startRead(22'h0003F2);
    waitAck(600, to, lat, ms, ec);
    checkOutput("rst_new_timeout", 64'(to), 64'd0);
    checkOutput("rst_new_miss", 64'(ms), 64'd1);
    checkOutput("rst_new_data", 64'(cpu_dout), 64'(expWord(22'h0003F2)));
    checkOutput("rst_new_latency", 64'(lat), 64'd2);
    checkOutput("rst_new_mem_addr", 64'(lastFillLine), 64'(22'h0003F2 >> 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
